// File: rtl/cnt_pwm_pkg.sv
// Shared definitions for the counter-synchronised PWM controller.
//   state_t    : 2-bit controller state encoding
//   CNT_W_DEF  : default width of the system count and duty values
//   PCNT_W_DEF : default width of the completed-period counter
package cnt_pwm_pkg;

   localparam int CNT_W_DEF  = 4;
   localparam int PCNT_W_DEF = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SYNC  = 2'd1,
      ST_RUN   = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   // RUN and DRAIN both drive the PWM and count completed periods.
   function automatic logic is_active(input state_t s);
      return (s == ST_RUN) || (s == ST_DRAIN);
   endfunction

endpackage

// File: rtl/duty_shadow_reg.sv
// Duty double buffer: a one-deep pending slot filled by a valid/ready
// handshake, and an active value that is only reloaded at a count wrap.
//   clk, rst  : system clock, async active-high reset
//   wrap      : one-clk strobe marking the start of a new period
//   duty_in   : requested duty, qualified by duty_vld
//   duty_rdy  : pending slot empty
//   duty_nxt  : duty value in force after this clk edge (active value,
//               or the pending value when it is promoted on this wrap)
module duty_shadow_reg #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         wrap,
   input  logic [W-1:0] duty_in,
   input  logic         duty_vld,
   output logic         duty_rdy,
   output logic [W-1:0] duty_nxt
);

   logic         pend_full;
   logic [W-1:0] pend_val;
   logic [W-1:0] duty_act;

   assign duty_rdy = !pend_full;
   assign duty_nxt = (wrap && pend_full) ? pend_val : duty_act;

   // Promotion needs a full slot and a capture needs an empty one, so the
   // two updates to pend_full below never fire on the same clk. A value
   // captured on a wrap clk therefore waits for the following wrap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_full <= 1'b0;
         pend_val  <= '0;
         duty_act  <= '0;
      end else begin
         if (wrap && pend_full) begin
            duty_act  <= pend_val;
            pend_full <= 1'b0;
         end
         if (duty_vld && !pend_full) begin
            pend_val  <= duty_in;
            pend_full <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/cnt_pwm_ctrl.sv
// PWM controller locked to an upstream free-running counter.
// Periods start at the counter wrap (15->0); duty changes land only on a
// wrap, and a stop request lets the current period finish first.
//   clk, rst     : system clock, async active-high reset
//   syscnt       : upstream free-running count
//   en           : run request (level)
//   duty_in/vld  : duty handshake input, duty_rdy = slot free
//   pwm_out      : registered PWM output
//   period_done  : one-clk pulse per completed period
//   period_cnt   : completed periods, modulo 2^PCNT_W
//   busy         : controller not idle
//
// state    | meaning
// ST_IDLE  | stopped, output low, period count held
// ST_SYNC  | enabled, waiting for the next wrap to start a period
// ST_RUN   | generating PWM periods
// ST_DRAIN | stop requested, finishing the current period
module cnt_pwm_ctrl
   import cnt_pwm_pkg::*;
#(
   parameter int CNT_W  = CNT_W_DEF,
   parameter int PCNT_W = PCNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [CNT_W-1:0]  syscnt,
   input  logic              en,
   input  logic [CNT_W-1:0]  duty_in,
   input  logic              duty_vld,
   output logic              duty_rdy,
   output logic              pwm_out,
   output logic              period_done,
   output logic [PCNT_W-1:0] period_cnt,
   output logic              busy
);

   logic [CNT_W-1:0] syscnt_d;
   logic [CNT_W-1:0] duty_nxt;
   logic             wrap;
   state_t           state;
   state_t           state_nxt;

   assign wrap = (syscnt == '0) && (syscnt_d == '1);
   assign busy = (state != ST_IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) syscnt_d <= '0;
      else     syscnt_d <= syscnt;
   end

   duty_shadow_reg #(.W(CNT_W)) u_shadow (
      .clk      (clk),
      .rst      (rst),
      .wrap     (wrap),
      .duty_in  (duty_in),
      .duty_vld (duty_vld),
      .duty_rdy (duty_rdy),
      .duty_nxt (duty_nxt)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (en)        state_nxt = ST_SYNC;
         ST_SYNC:  if (!en)       state_nxt = ST_IDLE;
                   else if (wrap) state_nxt = ST_RUN;
         ST_RUN:   if (!en)       state_nxt = ST_DRAIN;
         ST_DRAIN: if (en)        state_nxt = ST_RUN;
                   else if (wrap) state_nxt = ST_IDLE;
         default:                 state_nxt = ST_IDLE;
      endcase
   end

   // The compare uses the state and duty that apply from this edge on, so
   // the syscnt==0 slot of a period already belongs to that period: the
   // first RUN period is full-length and a new duty never leaks its first
   // slot from the old value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         pwm_out     <= 1'b0;
         period_done <= 1'b0;
         period_cnt  <= '0;
      end else begin
         state       <= state_nxt;
         pwm_out     <= is_active(state_nxt) && (syscnt < duty_nxt);
         period_done <= wrap && is_active(state);
         if (wrap && is_active(state))
            period_cnt <= period_cnt + PCNT_W'(1);
         else if (state == ST_IDLE && state_nxt == ST_SYNC)
            period_cnt <= '0;
      end
   end

endmodule

// File: tb/tb_cnt_pwm_ctrl.sv
module tb_cnt_pwm_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] syscnt;
   logic       en;
   logic [3:0] duty_in;
   logic       duty_vld;
   logic       duty_rdy;
   logic       pwm_out;
   logic       period_done;
   logic [7:0] period_cnt;
   logic       busy;

   cnt_pwm_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .syscnt      (syscnt),
      .en          (en),
      .duty_in     (duty_in),
      .duty_vld    (duty_vld),
      .duty_rdy    (duty_rdy),
      .pwm_out     (pwm_out),
      .period_done (period_done),
      .period_cnt  (period_cnt),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   // reference model: controller mode, pending queue, duty in force
   localparam int M_OFF = 0, M_WAIT = 1, M_ON = 2, M_STOP = 3;
   int m_mode, m_act, m_pcnt, m_prev;
   int pq[$];
   int n_chk, n_pass, n_cyc;
   int hi, pd;

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
   endtask

   task automatic model_reset();
      m_mode = M_OFF; m_act = 0; m_pcnt = 0; m_prev = 0;
      pq.delete();
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_pwm"}, int'(pwm_out), 0);
      chk({tag, "_pd"}, int'(period_done), 0);
      chk({tag, "_pcnt"}, int'(period_cnt), 0);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_rdy"}, int'(duty_rdy), 1);
   endtask

   // One clock: predict from the inputs presented, clock, compare, advance syscnt.
   task automatic cycle();
      bit wrap, xfer, e_pd, e_pwm;
      wrap = (syscnt == 4'd0) && (m_prev == 15);
      xfer = duty_vld && (pq.size() == 0);
      if (wrap && pq.size() != 0) m_act = pq.pop_front();
      if (xfer) pq.push_back(int'(duty_in));
      e_pd = wrap && (m_mode == M_ON || m_mode == M_STOP);
      if (e_pd) m_pcnt = (m_pcnt + 1) % 256;
      case (m_mode)
         M_OFF:  if (en) begin m_mode = M_WAIT; m_pcnt = 0; end
         M_WAIT: if (!en) m_mode = M_OFF; else if (wrap) m_mode = M_ON;
         M_ON:   if (!en) m_mode = M_STOP;
         default: if (en) m_mode = M_ON; else if (wrap) m_mode = M_OFF;
      endcase
      e_pwm = (m_mode == M_ON || m_mode == M_STOP) && (int'(syscnt) < m_act);
      m_prev = int'(syscnt);
      @(posedge clk); #1;
      chk("pwm", int'(pwm_out), int'(e_pwm));
      chk("period_done", int'(period_done), int'(e_pd));
      chk("period_cnt", int'(period_cnt), m_pcnt);
      chk("busy", int'(busy), int'(m_mode != M_OFF));
      chk("duty_rdy", int'(duty_rdy), int'(pq.size() == 0));
      hi += int'(pwm_out);
      pd += int'(period_done);
      syscnt = syscnt + 4'd1;
      n_cyc++;
      if (n_cyc > 60000) begin
         $display("FAIL cycle_budget observed=%0d limit=60000", n_cyc);
         $fatal(1, "cycle budget exceeded");
      end
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic run_to(input int target);
      int n = 0;
      while (int'(syscnt) != target && n < 32) begin cycle(); n++; end
      chk("run_to", int'(syscnt), target);
   endtask

   initial begin
      n_chk = 0; n_pass = 0; n_cyc = 0; hi = 0; pd = 0;
      rst = 1'b1; en = 1'b0; duty_in = 4'd0; duty_vld = 1'b0; syscnt = 4'd0;
      model_reset();

      // reset for 1000 ns with the upstream counter running
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         syscnt = syscnt + 4'd1;
      end
      check_reset_outputs("reset");
      rst = 1'b0;

      // enable with duty 4 offered in IDLE; first period has 4 high clks
      en = 1'b1; duty_vld = 1'b1; duty_in = 4'd4;
      cycle();
      duty_vld = 1'b0;
      chk("accept_rdy_low", int'(duty_rdy), 0);
      chk("sync_busy", int'(busy), 1);
      run_to(0);
      hi = 0;
      cycle();
      chk("first_rise", int'(pwm_out), 1);
      cycles(15);
      chk("first_period_hi", hi, 4);

      // duty 12 sent mid-period: current period stays 4, next has 12
      hi = 0;
      cycles(5);
      duty_vld = 1'b1; duty_in = 4'd12;
      cycle();
      duty_vld = 1'b0;
      chk("mid_rdy_low", int'(duty_rdy), 0);
      cycles(10);
      chk("mid_rdy_still_low", int'(duty_rdy), 0);
      chk("old_period_hi", hi, 4);
      hi = 0;
      cycle();
      chk("rdy_back_after_wrap", int'(duty_rdy), 1);
      cycles(15);
      chk("new_period_hi", hi, 12);

      // duty 9 offered on the wrap clk: lands one period later
      chk("at_wrap", int'(syscnt), 0);
      duty_vld = 1'b1; duty_in = 4'd9;
      hi = 0;
      cycle();
      duty_vld = 1'b0;
      chk("wrap_xfer_rdy", int'(duty_rdy), 0);
      cycles(15);
      chk("wrap_xfer_keep12", hi, 12);
      hi = 0;
      cycles(16);
      chk("wrap_xfer_apply9", hi, 9);
      chk("wrap_xfer_rdy_back", int'(duty_rdy), 1);

      // en dropped at syscnt=6: the period completes, then IDLE
      cycles(6);
      en = 1'b0;
      pd = 0;
      cycles(11);
      chk("drain_one_pulse", pd, 1);
      chk("drain_idle_busy", int'(busy), 0);
      chk("drain_idle_pwm", int'(pwm_out), 0);
      cycles(5);
      chk("idle_no_pulse", pd, 1);

      // randomized en / duty traffic
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 39) == 0) en = ~en;
         duty_vld = ($urandom_range(0, 3) == 0);
         duty_in = 4'($urandom_range(0, 15));
         cycle();
      end
      duty_vld = 1'b0;

      // 256 periods: period_cnt wraps 255->0; new en clears the count first
      en = 1'b0;
      cycles(40);
      chk("idle_after_stop", int'(busy), 0);
      en = 1'b1;
      cycle();
      chk("en_clears_cnt", int'(period_cnt), 0);
      pd = 0;
      for (int i = 0; i < 4200 && pd < 256; i++) begin
         duty_vld = ($urandom_range(0, 7) == 0);
         duty_in = 4'($urandom_range(0, 15));
         cycle();
         if (period_done && pd == 255) chk("pcnt_255", int'(period_cnt), 255);
      end
      duty_vld = 1'b0;
      chk("pulses_256", pd, 256);
      chk("pcnt_wrapped", int'(period_cnt), 0);

      // reset asserted at syscnt=10 while running
      run_to(10);
      chk("pre_rst_busy", int'(busy), 1);
      pd = 0;
      rst = 1'b1;
      #1;
      check_reset_outputs("async_rst");
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         pd += int'(period_done);
         syscnt = syscnt + 4'd1;
      end
      check_reset_outputs("rst_held");
      chk("rst_no_pulse", pd, 0);
      model_reset();
      en = 1'b0;
      rst = 1'b0;
      cycles(4);
      chk("stay_idle_en0", int'(busy), 0);
      en = 1'b1;
      duty_vld = 1'b1; duty_in = 4'd7;
      cycle();
      duty_vld = 1'b0;
      chk("resync_busy", int'(busy), 1);
      cycles(40);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/cnt_pwm_ctrl.md
CNT_PWM_CTRL -- requirements
Module: cnt_pwm_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 4, width of the incoming system count and duty values.
REQ-002 SHALL have parameter PCNT_W, default 8, width of the completed-period counter.
REQ-003 clk  input  1  system clock, 100 MHz nominal; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 syscnt  input  CNT_W  free-running count from the upstream counter stage, incrementing by 1 per clk, wrapping 15->0.
REQ-006 en  input  1  run request; level-sensitive.
REQ-007 duty_in  input  CNT_W  requested high-time in counts per period.
REQ-008 duty_vld  input  1  duty_in valid.
REQ-009 duty_rdy  output  1  pending duty slot empty, so a duty value can be accepted.
REQ-010 pwm_out  output  1  registered PWM output.
REQ-011 period_done  output  1  one-clk pulse per completed RUN period.
REQ-012 period_cnt  output  PCNT_W  completed RUN periods, modulo 2^PCNT_W.
REQ-013 busy  output  1  high whenever the state is not IDLE.

Function
REQ-014 SHALL register syscnt into syscnt_d every clk; wrap = (syscnt==0) && (syscnt_d==2^CNT_W-1).
REQ-015 SHALL implement the FSM states IDLE, SYNC, RUN and DRAIN.
REQ-016 IDLE->SYNC when en=1.
REQ-017 SYNC->RUN on wrap; SYNC->IDLE if en=0 before the wrap.
REQ-018 RUN->DRAIN when en=0; DRAIN->IDLE on the next wrap, so the current period always completes.
REQ-019 DRAIN->RUN if en returns to 1 before the wrap, with no gap in the period.
REQ-020 In RUN and DRAIN, pwm_out SHALL be set on the next clk to (syscnt < duty_act), giving 1-clk latency from syscnt to pwm_out.
REQ-021 In IDLE and SYNC, pwm_out SHALL be set to 0.
REQ-022 duty_act=0 SHALL give pwm_out constantly low; duty_act=15 SHALL give 15 high clks out of 16.
REQ-023 Duty handshake: a transfer occurs when duty_vld && duty_rdy; duty_in is captured into the pending register and duty_rdy drops to 0 on the next clk.
REQ-024 On wrap, if the pending register is full, pending SHALL move to duty_act and duty_rdy SHALL return to 1 on the next clk, in every state.
REQ-025 If a transfer and a wrap occur in the same clk with pending empty, the new value SHALL go to pending and take effect at the following wrap.
REQ-026 duty_act SHALL NOT change except on wrap, so the output never glitches mid-period.
REQ-027 period_done SHALL pulse for 1 clk on each wrap while the state is RUN or DRAIN.
REQ-028 period_cnt SHALL increment on the same clk as period_done, wrapping 255->0 at the default width.
REQ-029 period_cnt SHALL hold in IDLE and SHALL clear on the IDLE->SYNC transition.
REQ-030 busy = (state != IDLE).

Reset
REQ-031 While rst=1, SHALL immediately force: state=IDLE, pwm_out=0, period_done=0, period_cnt=0, duty_act=0, pending empty, duty_rdy=1, syscnt_d=0.
REQ-032 Reset asserted mid-period SHALL abort the period with no period_done pulse.
REQ-033 After rst is released, SHALL re-enter SYNC only if en=1 on a subsequent clk.

Structure
REQ-034 SHALL place the FSM state encoding (2-bit, IDLE=0, SYNC=1, RUN=2, DRAIN=3) and the default CNT_W/PCNT_W constants in the shared package cnt_pwm_pkg.
REQ-035 SHALL implement the duty pending/active double buffer and its handshake as the sub-module duty_shadow_reg; the FSM and PWM comparator remain in the top module.

Verification
REQ-036 Reset 1000 ns, then en=1, duty 4 accepted in IDLE -> the first wrap enters RUN with duty_act=4; pwm_out high for exactly 4 of 16 clks, rising 1 clk after syscnt==0.
REQ-037 RUN with duty 4, duty 12 sent mid-period -> duty_rdy low until the wrap; the current period keeps 4 high clks and the next period has 12; duty_rdy returns to 1 one clk after the wrap.
REQ-038 duty_vld held on the wrap clk with pending empty, duty 9 -> duty 9 is applied one period later, not immediately.
REQ-039 en dropped at syscnt=6 -> the period completes, one period_done pulse, IDLE after the wrap, pwm_out=0 and busy=0.
REQ-040 Run 256 periods (20*16*2 clks per segment, repeated) -> period_cnt wraps 255->0 with a period_done pulse on every wrap; a new en clears the count.
REQ-041 rst asserted at syscnt=10 in RUN -> all outputs return to their reset values immediately and no period_done pulse is produced.
